vta_host_req_queue: RTL and testbench

Parametrised host-request bridge between the simulation host (DPI driver side) and the VTA CSR/register interface. It buffers host read/write requests in a DEPTH-entry FIFO and presents them to the device one at a time with a valid/dequeue handshake. It tracks up to MAX_RD outstanding reads, returns read data in order, and emits timeout error responses. It also provides a 64-bit free-running cycle counter for run statistics.

---
 rtl/vta_host_req_queue.sv | 191 +++++++++++++++++++
 tb/tb_vta_host_req_queue.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vta_host_req_queue.sv
// vta_host_req_queue
// Host-request bridge between the simulation host driver and the VTA CSR
// interface. Host requests are buffered in a DEPTH-entry FIFO and offered to
// the device one at a time. Up to MAX_RD reads may be issued but unanswered.
// Device read data is returned to the host in order. A read left unanswered
// for TIMEOUT cycles is retired with an error response.
//
// Ports
//   clock, reset_n            : clock (rising edge), asynchronous active-low reset
//   host_req_*                : host request channel (valid/ready, opcode 1=write)
//   host_resp_valid/bits/err  : one-cycle read response pulse; err=1 on timeout
//   dev_req_*                 : FIFO head presented to device; dev_req_deq pops it
//   dev_resp_valid/bits       : device read response
//   fifo_count                : occupied FIFO entries
//   rd_outstanding            : reads issued and not yet answered
//   spurious_err              : sticky, response seen with no read in flight
//   cycles                    : 64-bit free-running cycle counter
module vta_host_req_queue #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 32,
    parameter int DEPTH     = 4,
    parameter int MAX_RD    = 4,
    parameter int TIMEOUT   = 1024
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        host_req_valid,
    output logic                        host_req_ready,
    input  logic                        host_req_opcode,
    input  logic [ADDR_BITS-1:0]        host_req_addr,
    input  logic [DATA_BITS-1:0]        host_req_value,
    output logic                        host_resp_valid,
    output logic [DATA_BITS-1:0]        host_resp_bits,
    output logic                        host_resp_err,
    output logic                        dev_req_valid,
    output logic                        dev_req_opcode,
    output logic [ADDR_BITS-1:0]        dev_req_addr,
    output logic [DATA_BITS-1:0]        dev_req_value,
    input  logic                        dev_req_deq,
    input  logic                        dev_resp_valid,
    input  logic [DATA_BITS-1:0]        dev_resp_bits,
    output logic [$clog2(DEPTH):0]      fifo_count,
    output logic [$clog2(MAX_RD):0]     rd_outstanding,
    output logic                        spurious_err,
    output logic [63:0]                 cycles
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = $clog2(MAX_RD) + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int EW = 1 + ADDR_BITS + DATA_BITS;

    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [RW-1:0] MAX_RD_C   = RW'(MAX_RD);
    localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    // Entry layout: {opcode, addr, value}
    logic [EW-1:0]        mem_q [DEPTH];

    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [RW-1:0]        rd_out_q, rd_out_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic                 resp_valid_q, resp_valid_d;
    logic                 resp_err_q, resp_err_d;
    logic [DATA_BITS-1:0] resp_bits_q, resp_bits_d;
    logic                 spurious_q, spurious_d;
    logic [63:0]          cycles_q, cycles_d;

    logic [EW-1:0]        head;
    logic                 head_op;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 rd_pop;
    logic                 resp_acc;
    logic                 timeout_fire;
    logic                 rd_dec;

    assign head       = mem_q[rd_ptr_q];
    assign head_op    = head[EW-1];
    assign fifo_empty = (count_q == '0);

    // Ready depends only on registered occupancy; reset_n gating keeps it low
    // while the block is held in reset.
    assign host_req_ready = reset_n && (count_q != DEPTH_C);

    // A read at the head stalls while the outstanding-read budget is spent;
    // writes are never throttled.
    assign dev_req_valid  = !fifo_empty && (head_op || (rd_out_q < MAX_RD_C));
    assign dev_req_opcode = fifo_empty ? 1'b0 : head_op;
    assign dev_req_addr   = fifo_empty ? '0 : head[EW-2 -: ADDR_BITS];
    assign dev_req_value  = fifo_empty ? '0 : head[DATA_BITS-1:0];

    assign push     = host_req_valid && host_req_ready;
    assign pop      = dev_req_deq && dev_req_valid;
    assign rd_pop   = pop && !head_op;
    assign resp_acc = dev_resp_valid && (rd_out_q != '0);

    // Timeout only when no response arrives this cycle, so it can never
    // coincide with an accepted response.
    assign timeout_fire = (TIMEOUT != 0) && !dev_resp_valid && (rd_out_q != '0) &&
                          (timer_q == TIMER_LAST);
    assign rd_dec = resp_acc || timeout_fire;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        rd_out_d     = rd_out_q;
        timer_d      = timer_q;
        resp_valid_d = rd_dec;
        resp_err_d   = timeout_fire;
        resp_bits_d  = resp_bits_q;
        spurious_d   = spurious_q;
        cycles_d     = cycles_q + 64'd1;

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Read issue and read retirement in the same cycle cancel out.
        rd_out_d = rd_out_q + RW'(rd_pop) - RW'(rd_dec);

        // Timer measures time since the last response (or since reads began).
        if ((TIMEOUT == 0) || (rd_out_q == '0) || rd_dec) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end

        if (resp_acc) begin
            resp_bits_d = dev_resp_bits;
        end else if (timeout_fire) begin
            resp_bits_d = '0;
        end

        if (dev_resp_valid && (rd_out_q == '0)) begin
            spurious_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rd_out_q     <= '0;
            timer_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_bits_q  <= '0;
            spurious_q   <= 1'b0;
            cycles_q     <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rd_out_q     <= rd_out_d;
            timer_q      <= timer_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_bits_q  <= resp_bits_d;
            spurious_q   <= spurious_d;
            cycles_q     <= cycles_d;
        end
    end

    // FIFO storage is never read while empty, so it carries no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {host_req_opcode, host_req_addr, host_req_value};
        end
    end

    assign host_resp_valid = resp_valid_q;
    assign host_resp_err   = resp_err_q;
    assign host_resp_bits  = resp_bits_q;
    assign fifo_count      = count_q;
    assign rd_outstanding  = rd_out_q;
    assign spurious_err    = spurious_q;
    assign cycles          = cycles_q;

endmodule

// File: tb/tb_vta_host_req_queue.sv
// Testbench for vta_host_req_queue: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_vta_host_req_queue;

    localparam int AB    = 8;
    localparam int DB    = 32;
    localparam int DEPTH = 4;
    localparam int MAXRD = 2;
    localparam int TMO   = 8;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          host_req_valid = 1'b0;
    logic          host_req_ready;
    logic          host_req_opcode = 1'b0;
    logic [AB-1:0] host_req_addr = '0;
    logic [DB-1:0] host_req_value = '0;
    logic          host_resp_valid;
    logic [DB-1:0] host_resp_bits;
    logic          host_resp_err;
    logic          dev_req_valid;
    logic          dev_req_opcode;
    logic [AB-1:0] dev_req_addr;
    logic [DB-1:0] dev_req_value;
    logic          dev_req_deq = 1'b0;
    logic          dev_resp_valid = 1'b0;
    logic [DB-1:0] dev_resp_bits = '0;
    logic [2:0]    fifo_count;
    logic [1:0]    rd_outstanding;
    logic          spurious_err;
    logic [63:0]   cycles;

    vta_host_req_queue #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .DEPTH(DEPTH), .MAX_RD(MAXRD), .TIMEOUT(TMO)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
        .host_req_opcode(host_req_opcode), .host_req_addr(host_req_addr),
        .host_req_value(host_req_value),
        .host_resp_valid(host_resp_valid), .host_resp_bits(host_resp_bits),
        .host_resp_err(host_resp_err),
        .dev_req_valid(dev_req_valid), .dev_req_opcode(dev_req_opcode),
        .dev_req_addr(dev_req_addr), .dev_req_value(dev_req_value),
        .dev_req_deq(dev_req_deq),
        .dev_resp_valid(dev_resp_valid), .dev_resp_bits(dev_resp_bits),
        .fifo_count(fifo_count), .rd_outstanding(rd_outstanding),
        .spurious_err(spurious_err), .cycles(cycles)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog sim_time=%0t limit=2000000", $time);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic          op;
        logic [AB-1:0] addr;
        logic [DB-1:0] val;
    } req_t;

    // Reference model state
    req_t              mq[$];
    int                m_out;
    int                m_timer;
    bit                m_spur;
    longint unsigned   m_cyc;
    bit                m_rv;
    bit                m_rerr;
    logic [DB-1:0]     m_rbits;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_out   = 0;
        m_timer = 0;
        m_spur  = 0;
        m_cyc   = 0;
        m_rv    = 0;
        m_rerr  = 0;
        m_rbits = '0;
    endtask

    task automatic compare_all();
        bit exp_dv;
        exp_dv = (mq.size() > 0) && (mq[0].op || (m_out < MAXRD));
        chk("ready", host_req_ready, (mq.size() < DEPTH));
        chk("fifo_count", fifo_count, mq.size());
        chk("dev_req_valid", dev_req_valid, exp_dv);
        if (mq.size() > 0) begin
            chk("dev_req_opcode", dev_req_opcode, mq[0].op);
            chk("dev_req_addr", dev_req_addr, mq[0].addr);
            chk("dev_req_value", dev_req_value, mq[0].val);
        end else begin
            chk("dev_req_empty", {dev_req_opcode, dev_req_addr, dev_req_value}, '0);
        end
        chk("rd_outstanding", rd_outstanding, m_out);
        chk("host_resp_valid", host_resp_valid, m_rv);
        if (m_rv) begin
            chk("host_resp_bits", host_resp_bits, m_rbits);
            chk("host_resp_err", host_resp_err, m_rerr);
        end
        chk("spurious_err", spurious_err, m_spur);
        chk("cycles", cycles, m_cyc);
    endtask

    // Drive one cycle of inputs (called at a negedge), advance the model over
    // the following rising edge, then compare at the next negedge.
    task automatic step(input bit hv, input bit hop, input logic [AB-1:0] ha,
                        input logic [DB-1:0] hval, input bit deq,
                        input bit dresp, input logic [DB-1:0] dbits);
        bit dv, pop, push, racc, tmo, popread;
        req_t r;
        host_req_valid  = hv;
        host_req_opcode = hop;
        host_req_addr   = ha;
        host_req_value  = hval;
        dev_req_deq     = deq;
        dev_resp_valid  = dresp;
        dev_resp_bits   = dbits;

        dv      = (mq.size() > 0) && (mq[0].op || (m_out < MAXRD));
        pop     = deq && dv;
        popread = pop && !mq[0].op;
        push    = hv && (mq.size() < DEPTH);
        racc    = dresp && (m_out > 0);
        tmo     = !dresp && (m_out > 0) && (m_timer == TMO - 1);
        m_rv    = racc || tmo;
        if (m_rv) begin
            m_rbits = racc ? dbits : '0;
            m_rerr  = tmo;
        end
        if (dresp && m_out == 0) m_spur = 1;
        if (m_out == 0 || racc || tmo) m_timer = 0;
        else m_timer++;
        m_out = m_out + int'(popread) - int'(racc || tmo);
        if (pop) void'(mq.pop_front());
        if (push) begin
            r.op = hop; r.addr = ha; r.val = hval;
            mq.push_back(r);
        end
        m_cyc++;

        @(negedge clock);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0);
    endtask

    initial begin
        int k;
        bit seen;
        model_reset();

        // Reset held for 3 cycles with a request offered: nothing may happen.
        host_req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("rst_ready", host_req_ready, 1'b0);
            chk("rst_count", fifo_count, 0);
            chk("rst_rd_out", rd_outstanding, 0);
            chk("rst_resp_valid", host_resp_valid, 1'b0);
            chk("rst_spurious", spurious_err, 1'b0);
            chk("rst_cycles", cycles, 64'd0);
        end
        reset_n = 1'b1;
        host_req_valid = 1'b0;

        // First push on the first edge after release.
        step(1, 1, 8'h33, 32'h0000_1111, 0, 0, '0);
        chk("first_push_count", fifo_count, 1);
        step(0, 0, '0, '0, 1, 0, '0);

        // Write then read, answered by the device.
        step(1, 1, 8'h10, 32'hDEAD_BEEF, 0, 0, '0);
        step(1, 0, 8'h10, 32'h0, 1, 0, '0);
        step(0, 0, '0, '0, 1, 0, '0);
        chk("wr_rd_out_after_issue", rd_outstanding, 1);
        step(0, 0, '0, '0, 0, 1, 32'hDEAD_BEEF);
        chk("wr_rd_resp_valid", host_resp_valid, 1'b1);
        chk("wr_rd_resp_bits", host_resp_bits, 32'hDEAD_BEEF);
        chk("wr_rd_resp_err", host_resp_err, 1'b0);
        chk("wr_rd_out_zero", rd_outstanding, 0);
        idle(1);
        chk("wr_rd_pulse_once", host_resp_valid, 1'b0);

        // Fill: five offered, four accepted.
        for (int i = 0; i < 5; i++)
            step(1, 1, AB'(8'h40 + i), $urandom, 0, 0, '0);
        chk("fill_count", fifo_count, 4);
        chk("fill_ready", host_req_ready, 1'b0);
        step(1, 1, 8'h50, 32'h5050_5050, 1, 0, '0);
        chk("full_pop_count", fifo_count, 3);
        step(1, 1, 8'h51, 32'h5151_5151, 1, 0, '0);
        chk("push_pop_count", fifo_count, 3);
        for (int i = 0; i < 3; i++) step(0, 0, '0, '0, 1, 0, '0);
        chk("drain_count", fifo_count, 0);

        // Read throttle at MAX_RD = 2.
        for (int i = 0; i < 3; i++) step(1, 0, AB'(8'h60 + i), '0, 0, 0, '0);
        step(0, 0, '0, '0, 1, 0, '0);
        step(0, 0, '0, '0, 1, 0, '0);
        step(0, 0, '0, '0, 1, 0, '0);
        chk("throttle_valid_low", dev_req_valid, 1'b0);
        chk("throttle_rd_out", rd_outstanding, 2);
        step(0, 0, '0, '0, 0, 1, 32'h0000_00A1);
        chk("throttle_release", dev_req_valid, 1'b1);
        step(0, 0, '0, '0, 1, 0, '0);
        chk("throttle_fifo_empty", fifo_count, 0);
        idle(20);
        chk("throttle_settled", rd_outstanding, 0);

        // Timeout: one read, no response, error exactly 8 cycles after issue.
        step(1, 0, 8'h70, '0, 0, 0, '0);
        step(0, 0, '0, '0, 1, 0, '0);
        k = 0;
        seen = 0;
        while (!seen && k < 20) begin
            idle(1);
            k++;
            if (host_resp_valid) seen = 1;
        end
        chk("timeout_latency", k, 8);
        chk("timeout_err", host_resp_err, 1'b1);
        chk("timeout_bits", host_resp_bits, '0);
        chk("timeout_rd_out", rd_outstanding, 0);

        // Spurious response with nothing in flight.
        step(0, 0, '0, '0, 0, 1, 32'h1234_5678);
        chk("spur_no_resp", host_resp_valid, 1'b0);
        chk("spur_flag", spurious_err, 1'b1);
        idle(3);
        chk("spur_sticky", spurious_err, 1'b1);

        // Random traffic with one asynchronous reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                #2 reset_n = 1'b0;
                model_reset();
                #1;
                chk("midrst_count", fifo_count, 0);
                chk("midrst_rd_out", rd_outstanding, 0);
                chk("midrst_ready", host_req_ready, 1'b0);
                chk("midrst_spurious", spurious_err, 1'b0);
                chk("midrst_resp_valid", host_resp_valid, 1'b0);
                @(negedge clock);
                reset_n = 1'b1;
            end
            step(($urandom_range(0, 9) < 6), $urandom_range(0, 1), AB'($urandom),
                 $urandom, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3),
                 $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
